// File: rtl/const_div_pkg.sv
// rtl/const_div_pkg.sv - shared constants and FSM state type for the constant divider
package const_div_pkg;

  localparam int DIV_DEFAULT   = 1532;
  localparam int REM_W_DEFAULT = $clog2(DIV_DEFAULT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/const_div_step.sv
// rtl/const_div_step.sv - one combinational restoring-division step by a constant divisor
module const_div_step #(
  parameter int DIVISOR = 1532,
  parameter int REM_W   = $clog2(DIVISOR)
) (
  input  logic [REM_W-1:0] rem,
  input  logic             in_bit,
  output logic [REM_W-1:0] rem_next,
  output logic             q_bit
);

  localparam logic [REM_W:0] DIV_V = (REM_W+1)'(DIVISOR);

  logic [REM_W:0] t;

  // rem < DIVISOR on entry keeps t below 2*DIVISOR, so one subtract suffices
  always_comb begin
    t        = {rem, in_bit};
    q_bit    = (t >= DIV_V);
    rem_next = q_bit ? REM_W'(t - DIV_V) : t[REM_W-1:0];
  end

endmodule

// File: rtl/const_div1532_seq.sv
// rtl/const_div1532_seq.sv - bit-serial restoring divider by 1532 with valid/ready handshakes
module const_div1532_seq
  import const_div_pkg::*;
#(
  parameter int  WIDTH   = 32,
  parameter int  DIVISOR = DIV_DEFAULT,
  localparam int REM_W   = $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data0,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data0,
  output logic [REM_W-1:0] o_rem
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sh;
  logic [REM_W-1:0] rem;
  logic [REM_W-1:0] rem_next;
  logic             q_bit;

  const_div_step #(
    .DIVISOR(DIVISOR),
    .REM_W  (REM_W)
  ) u_step (
    .rem     (rem),
    .in_bit  (sh[WIDTH-1]),
    .rem_next(rem_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_valid) state_next = BUSY;
      BUSY:    if (cnt == CNT_W'(1)) state_next = DONE;
      DONE:    if (i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // sh holds the dividend and fills from the LSB with quotient bits
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sh  <= '0;
      rem <= '0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          sh  <= i_data0;
          rem <= '0;
          cnt <= CNT_W'(WIDTH);
        end
        BUSY: begin
          sh  <= {sh[WIDTH-2:0], q_bit};
          rem <= rem_next;
          cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_ready = (state == IDLE) && !rst;
  assign o_valid = (state == DONE);
  assign o_data0 = sh;
  assign o_rem   = rem;

endmodule

// File: tb/tb_const_div1532_seq.sv
// tb/tb_const_div1532_seq.sv - directed and table-driven checks for const_div1532_seq
module tb_const_div1532_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data0;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data0;
  logic [10:0] o_rem;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  const_div1532_seq dut (
    .clk    (clk),
    .rst    (rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data0(i_data0),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data0(o_data0),
    .o_rem  (o_rem)
  );

  typedef struct {
    logic [31:0] d;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [31:0] d,
                        input logic [31:0] eq, input logic [31:0] er);
    int n;
    n = 0;
    while (!o_ready && n < 100) begin
      tick();
      n++;
    end
    chk({name, " ready"}, {31'b0, o_ready}, 32'd1);
    i_valid = 1'b1;
    i_data0 = d;
    tick();
    i_valid = 1'b0;
    i_data0 = $urandom;
    n = 0;
    while (!o_valid && n < 100) begin
      tick();
      n++;
    end
    chk({name, " latency"}, n, 32'd32);
    chk({name, " q"}, o_data0, eq);
    chk({name, " r"}, {21'b0, o_rem}, er);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk({name, " release"}, {30'b0, o_valid, o_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] bq [$];
    logic [31:0] d;
    logic [31:0] x;
    int          n, cyc, acc_cnt, res_cnt, last_acc;
    logic        acc, xfer;

    vecs[0] = '{32'd1532000,  32'd1000,    32'd0};
    vecs[1] = '{32'd0,        32'd0,       32'd0};
    vecs[2] = '{32'd1531,     32'd0,       32'd1531};
    vecs[3] = '{32'd1532,     32'd1,       32'd0};
    vecs[4] = '{32'hFFFFFFFF, 32'd2803503, 32'd699};
    vecs[5] = '{32'd1533,     32'd1,       32'd1};
    vecs[6] = '{32'd3063,     32'd1,       32'd1531};
    vecs[7] = '{32'd100000,   32'd65,      32'd420};

    rst     = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data0 = 32'd0;
    tick();
    tick();
    chk("reset o_valid", {31'b0, o_valid}, 32'd0);
    chk("reset o_ready", {31'b0, o_ready}, 32'd0);
    chk("reset o_data0", o_data0, 32'd0);
    chk("reset o_rem", {21'b0, o_rem}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready after reset", {31'b0, o_ready}, 32'd1);

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].q, vecs[i].r);

    // backpressure: hold result in DONE while poking i_valid
    i_valid = 1'b1;
    i_data0 = 32'd1532000;
    tick();
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 100) begin
      tick();
      n++;
    end
    chk("bp latency", n, 32'd32);
    for (int c = 0; c < 10; c++) begin
      i_valid = c[0];
      i_data0 = $urandom;
      tick();
      chk($sformatf("bp hold %0d", c),
          {o_valid, o_ready, o_rem, o_data0[18:0]},
          {1'b1, 1'b0, 11'd0, 19'd1000});
    end
    i_valid = 1'b0;
    chk("bp q", o_data0, 32'd1000);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("bp release", {30'b0, o_valid, o_ready}, 32'd1);
    run_op("after bp", 32'd4596, 32'd3, 32'd0);

    // reset during BUSY discards the operand
    i_valid = 1'b1;
    i_data0 = 32'd1532000;
    tick();
    i_valid = 1'b0;
    repeat (16) tick();
    rst = 1'b1;
    tick();
    chk("midrst o_valid", {31'b0, o_valid}, 32'd0);
    chk("midrst o_ready", {31'b0, o_ready}, 32'd0);
    chk("midrst o_data0", o_data0, 32'd0);
    chk("midrst o_rem", {21'b0, o_rem}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst ready", {31'b0, o_ready}, 32'd1);
    run_op("after rst", 32'd3064, 32'd2, 32'd0);

    // back-to-back with both handshakes tied high
    i_ready  = 1'b1;
    i_valid  = 1'b1;
    i_data0  = $urandom;
    cyc      = 0;
    acc_cnt  = 0;
    res_cnt  = 0;
    last_acc = -1;
    while (res_cnt < 1000 && cyc < 40000) begin
      acc  = o_ready && i_valid;
      xfer = o_valid && i_ready;
      if (xfer) begin
        if (bq.size() == 0) begin
          chk("b2b spurious result", 32'd1, 32'd0);
        end else begin
          d = bq.pop_front();
          chk($sformatf("b2b q %0d", d), o_data0, d / 32'd1532);
          chk($sformatf("b2b r %0d", d), {21'b0, o_rem}, d % 32'd1532);
        end
        res_cnt++;
      end
      if (acc) begin
        bq.push_back(i_data0);
        if (last_acc >= 0) chk("b2b spacing", cyc - last_acc, 32'd34);
        last_acc = cyc;
        acc_cnt++;
      end
      tick();
      cyc++;
      if (acc) i_data0 = $urandom;
      if (acc_cnt >= 1000) i_valid = 1'b0;
    end
    chk("b2b results", res_cnt, 32'd1000);
    i_valid = 1'b0;
    i_ready = 1'b0;
    tick();

    // round trip through the x1532 scaling
    run_op("rt 0", 32'd0, 32'd0, 32'd0);
    run_op("rt max", 32'd2803503 * 32'd1532, 32'd2803503, 32'd0);
    for (int k = 0; k < 20; k++) begin
      x = $urandom_range(2803503, 0);
      run_op($sformatf("rt %0d", x), x * 32'd1532, x, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/const_div1532_seq.md
# const_div1532_seq

Sequential restoring divider that inverts the constant multiply-by-1532 datapath. It accepts a 32-bit word over a valid/ready handshake and computes quotient and remainder by DIVISOR, one bit per cycle. Results are returned over a second valid/ready handshake. The block recovers the pre-scale operand from scaled results and checks that they are exact multiples (remainder zero).

## Interface
- WIDTH, 32, dividend/quotient width
- DIVISOR, 1532, constant divisor; legal range 2 ≤ DIVISOR < 2^WIDTH
- REM_W, $clog2(DIVISOR) (11 for 1532), remainder width; derived, not overridden

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  input operand valid
- o_ready  out  1  block can accept an operand
- i_data0  in  WIDTH  dividend
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_data0  out  WIDTH  quotient = i_data0 / DIVISOR
- o_rem  out  REM_W  remainder = i_data0 % DIVISOR

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid: latch i_data0 into the shift register, clear the partial remainder, load the bit counter with WIDTH, and go to BUSY.
- BUSY, each cycle:
  - t = {rem, dividend MSB}, REM_W+1 bits.
  - If t ≥ DIVISOR: rem ← t − DIVISOR and quotient bit = 1; else rem ← t and bit = 0.
  - Shift the quotient bit into the LSB; decrement the counter.
  - When the counter reaches 0, go to DONE.
- DONE:
  - o_valid=1; o_data0/o_rem are held stable.
  - On i_ready, go to IDLE and drop o_valid.
- o_ready=0 in BUSY and DONE. i_valid is ignored outside IDLE. i_data0 is sampled only at the accept edge.
- Arithmetic is unsigned only. The partial remainder never exceeds DIVISOR−1 after a step. The compare is REM_W+1 bits wide, so there is no overflow.
- o_data0 and o_rem are registered. They may show intermediate values during BUSY; they are meaningful only while o_valid=1.

## Timing
- Reset values: state IDLE, o_valid=0, o_data0=0, o_rem=0.
- o_ready is 0 while rst is high, then 1 from the first cycle after rst deasserts.
- Latency: accept at edge N (i_valid & o_ready) → o_valid high after edge N+WIDTH (32 cycles).
- Throughput: at best one operation per WIDTH+2 cycles (accept, 32 steps, one IDLE cycle after the result handshake). There is no accept in DONE.
- Result handshake: the transfer occurs on the edge where o_valid & i_ready. If i_ready is already high when DONE is entered, o_valid is high for exactly one cycle.
- Backpressure: o_valid and data hold indefinitely while i_ready=0.
- Reset mid-operation (BUSY or DONE): the next edge returns to IDLE with all outputs at reset values. The in-flight operand is discarded and no result is emitted.
- i_valid held high continuously: a new operand is taken each time IDLE is reached.

## Structure
- Shared package const_div_pkg:
  - DIVISOR default (1532) and the derived REM_W.
  - Typedef for the FSM state enum {IDLE, BUSY, DONE}.
- Sub-module const_div_step: combinational single restoring step.
  - Inputs: rem[REM_W-1:0], in_bit.
  - Outputs: rem_next[REM_W-1:0], q_bit.
  - Reused by the verification model.
- Top: FSM, counter ($clog2(WIDTH+1) bits), dividend/quotient shift register, remainder register.

## Test plan
- Reset, then i_data0=1532000 with i_valid → o_valid exactly 32 cycles after accept; o_data0=1000, o_rem=0.
- Boundaries: 0 → q=0, r=0; 1531 → q=0, r=1531; 1532 → q=1, r=0; 0xFFFFFFFF → q=0x2AC72F (2803503), r=699.
- Backpressure: hold i_ready=0 for 10 cycles in DONE → o_valid, o_data0 and o_rem stable; i_valid pulses in that window are ignored; o_ready=0 throughout.
- Reset asserted at step 16 of BUSY → next cycle IDLE, o_valid=0, outputs 0. The following operand 3064 → q=2, r=0 with full 32-cycle latency.
- Back-to-back with i_valid and i_ready tied high: 1000 random operands → each result matches floor division and modulus by 1532, and accepts are exactly 34 cycles apart.
- Round trip: x in [0, 2803503] through the ×1532 datapath then this block → o_data0=x, o_rem=0 for every sampled x.
